// File: rtl/imem_arbiter_if.sv
// Requester-side bus of the instruction memory arbiter.
// It carries two request ports (fetch = bit 0, debug = bit 1) sharing one response word.
interface imem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [1:0]        req_valid;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_ready;

    // Requester side: fetch unit and debug/loader port together
    modport master (
        output req_valid,
        output req_addr0,
        output req_addr1,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    // Arbiter side
    modport slave (
        input  req_valid,
        input  req_addr0,
        input  req_addr1,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter that shares one combinational-read instruction memory
// between the fetch port (0) and the debug/loader port (1).
// One transaction is outstanding at a time. The response word is registered and
// held until its owner takes it. A new grant may overlap the completing handshake,
// so a consumer that keeps rsp_ready high sees one word per cycle.
module imem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    imem_arbiter_if.slave     bus,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              own_q, own_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic              hold_done;
    logic              grant_ok;
    logic              grant;
    logic              winner;

    // The held response completes only when its owner consumes it. A new grant is possible in IDLE or on that completion, and never while reset is asserted.
    always_comb begin
        hold_done = (state_q == HOLD) && bus.rsp_ready[own_q];
        grant_ok  = (state_q == IDLE) || hold_done;
        grant     = !rst && grant_ok && (bus.req_valid != 2'b00);
        if (bus.req_valid == 2'b11) begin
            winner = ~last_q;
        end else if (bus.req_valid[0]) begin
            winner = 1'b0;
        end else begin
            winner = 1'b1;
        end
    end

    // State register; reset takes priority over everything else in the cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a grant always leads to HOLD (possibly with a new owner); otherwise a completed response returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (grant) begin
                    state_d = HOLD;
                end else if (hold_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: the memory is driven only in a grant cycle, and the response valid follows the current owner while in HOLD
    always_comb begin
        bus.req_ready = 2'b00;
        mem_read      = 1'b0;
        mem_addr      = '0;
        bus.rsp_valid = 2'b00;
        if (grant) begin
            bus.req_ready[winner] = 1'b1;
            mem_read              = 1'b1;
            mem_addr              = winner ? bus.req_addr1 : bus.req_addr0;
        end
        if (state_q == HOLD) begin
            bus.rsp_valid[own_q] = 1'b1;
        end
        bus.rsp_data = rsp_data_q;
    end

    // Datapath next values: capture the memory word, owner and round-robin pointer only on a grant
    always_comb begin
        last_d     = last_q;
        own_d      = own_q;
        rsp_data_d = rsp_data_q;
        if (grant) begin
            last_d     = winner;
            own_d      = winner;
            rsp_data_d = mem_rdata;
        end
    end

    // Datapath registers. last resets to 1 so that fetch wins the first contended grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= 1'b1;
            own_q      <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            last_q     <= last_d;
            own_q      <= own_d;
            rsp_data_q <= rsp_data_d;
        end
    end

endmodule
